trace_sequencer: RTL
====================

# trace_sequencer

- Upstream request stage for `cache_engine`.
- Buffers trace entries (48-bit address plus 8-bit action) in a small first-word-fall-through FIFO and replays them to the cache one request per accepted handshake.
- Filters out illegal actions and keeps saturating read/write/drop/issue counters.
- Signals completion once the entry tagged `in_last` has left the FIFO, so the bench can sample the L1/L2 statistics at a deterministic point.

## Interface
- `ADDR_W`, 48, address width.
- `OP_W`, 8, action width.
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥ 2.
- `CNT_W`, 18, counter width, matching the cache statistics counters.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: trace entry offered.
- `in_ready` out 1: `~full`.
- `in_addr` in `ADDR_W`: entry address.
- `in_op` in `OP_W`: entry action.
- `in_last` in 1: entry is the final one of the trace.
- `start` in 1: single-cycle pulse that begins replay.
- `out_valid` out 1: request presented to the cache.
- `out_ready` in 1: cache accepts; tie to 1 for `cache_engine`.
- `cache_addr` out `ADDR_W`: head address.
- `cache_op` out `OP_W`: head action.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `issued_count` out `CNT_W`: requests accepted by the cache.
- `read_count` out `CNT_W`: accepted read requests.
- `write_count` out `CNT_W`: accepted write requests.
- `dropped_count` out `CNT_W`: illegal entries discarded.

## Operation
- **Legal actions:** `OP_READ` = 8'h72 ('r') and `OP_WRITE` = 8'h77 ('w'). Any other value is illegal.
- **FIFO write:** occurs when `in_valid && in_ready`, in every state. Each entry stores {`in_last`, `in_op`, `in_addr`}.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `out_valid` = 0.
  - `start` → RUN. Clears all four counters and `last_issued`.
- **RUN:**
  - If the FIFO is non-empty and the head op is legal: `out_valid` = 1 and the head is presented.
  - Pop occurs on `out_valid && out_ready`. Increments `issued_count` and exactly one of `read_count` / `write_count`.
  - If the head op is illegal: `out_valid` stays 0 and the head is popped that cycle. `dropped_count` increments.
  - If the popped entry (issued or dropped) carries the last tag → DONE next cycle.
  - If the FIFO is empty: `out_valid` = 0 and the block waits; it does not leave RUN.
- **DONE:**
  - `done` = 1, `out_valid` = 0. Counters hold.
  - `start` → RUN with counters cleared. Entries still in the FIFO are replayed.
- `start` while in RUN is ignored.
- Counters saturate at all-ones. They never wrap.

## Timing
- **Reset values:**
  - State IDLE.
  - FIFO empty; read and write pointers = 0.
  - `in_ready` = 1.
  - `out_valid`, `busy`, `done` = 0.
  - All counters = 0.
  - `cache_addr`, `cache_op` = 0.
- **Reset mid-operation:** discards all FIFO contents and any in-flight presentation; the state machine returns to IDLE in the same edge.
- **Load-to-head latency:** an entry written at edge N is visible on `cache_addr`/`cache_op` after edge N (first-word fall-through, registered storage). It can be accepted at edge N+1.
- **Start-to-issue latency:** with a non-empty FIFO, `start` sampled at edge N gives `out_valid` = 1 in the following cycle. The first accept is at edge N+1.
- **Throughput:** one request per cycle while `out_ready` = 1 and the FIFO is not empty.
- **Stall:** while `out_valid && !out_ready`, `cache_addr` and `cache_op` are held stable.
- **Simultaneous push and pop:** both happen when the FIFO is not full; occupancy is unchanged.
- **Full FIFO:** `in_ready` = 0. There is no bypass, even when a pop happens in the same cycle.
- **Pointer wrap:** pointers are `$clog2(DEPTH)+1` bits; the extra MSB distinguishes full from empty.
- **Counter update:** counters update on the accept edge and are visible the next cycle.
- **`done`:** asserts the cycle after the last-tagged entry is popped.

## Structure
- **Package `cache_pkg`:** holds `OP_READ`, `OP_WRITE`, a `seq_state_t` enum {IDLE, RUN, DONE}, and a packed `trace_entry_t` {last, op, addr}. `cache_engine` benches share these.
- **Sub-module `sync_fifo`:** parameterised width/depth; first-word-fall-through; outputs `full`/`empty`. Synchronous reset.
- **`trace_sequencer`:** contains the FSM, the legality decode, and the saturating counters.

## Test plan
- **Basic replay:** load 4 entries (r 0x1000, w 0x2000, r 0x3000, w 0x4000 with last), pulse `start`, `out_ready` = 1.
  - Four consecutive accepts in order.
  - `issued` = 4, `read` = 2, `write` = 2.
  - `done` = 1 on the cycle after the 4th accept.
- **Illegal filtering:** entries r, 8'h00, w(last).
  - `cache_op` never presents 8'h00.
  - `dropped_count` = 1, `issued_count` = 2, then DONE.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles mid-stream.
  - `cache_addr`/`cache_op` are stable throughout.
  - No counter changes.
  - Resumes with the same entry.
- **Full/wrap:** push 16 entries → `in_ready` = 0. Then push and pop simultaneously for 40 entries.
  - Order is preserved across pointer wrap.
  - Occupancy is 16 → 16.
- **Reset mid-RUN:** assert `reset` after 3 accepts.
  - Next cycle: IDLE, FIFO empty, counters 0, `out_valid` = 0.
- **Saturation:** with `CNT_W` = 4, issue 20 reads.
  - `read_count` and `issued_count` hold at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and types for the trace sequencer and the cache_engine benches.
package cache_pkg;

    localparam int unsigned TRACE_ADDR_W = 48;
    localparam int unsigned TRACE_OP_W   = 8;

    localparam logic [TRACE_OP_W-1:0] OP_READ  = 8'h72;
    localparam logic [TRACE_OP_W-1:0] OP_WRITE = 8'h77;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                    last;
        logic [TRACE_OP_W-1:0]   op;
        logic [TRACE_ADDR_W-1:0] addr;
    } trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr + PW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Head register tracks mem[rd_ptr]; a write landing on the next read slot forwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_next;
            if (do_push && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
                head <= push_data;
            end else if (do_pop) begin
                head <= mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/trace_sequencer.sv
// Buffers trace entries and replays legal ones to the cache, dropping illegal actions
// and keeping saturating statistics until the last-tagged entry leaves the FIFO.
module trace_sequencer #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_last,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [OP_W-1:0]   cache_op,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_count,
    output logic [CNT_W-1:0]  read_count,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  dropped_count
);

    import cache_pkg::*;

    localparam int unsigned      ENTRY_W = 1 + OP_W + ADDR_W;
    localparam logic [OP_W-1:0]  RD_OP   = OP_W'(OP_READ);
    localparam logic [OP_W-1:0]  WR_OP   = OP_W'(OP_WRITE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t         state;
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               head_last;
    logic               head_is_rd;
    logic               head_is_wr;
    logic               head_legal;
    logic               pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data ({in_last, in_op, in_addr}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign cache_addr = head[ADDR_W-1:0];
    assign cache_op   = head[ADDR_W +: OP_W];
    assign head_last  = head[ENTRY_W-1];
    assign head_is_rd = (cache_op == RD_OP);
    assign head_is_wr = (cache_op == WR_OP);
    assign head_legal = head_is_rd || head_is_wr;

    // Illegal heads are discarded without waiting for the cache.
    assign out_valid = (state == RUN) && !fifo_empty && head_legal;
    assign pop       = (state == RUN) && !fifo_empty && (head_legal ? out_ready : 1'b1);
    assign in_ready  = !fifo_full;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            issued_count  <= '0;
            read_count    <= '0;
            write_count   <= '0;
            dropped_count <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= RUN;
                        issued_count  <= '0;
                        read_count    <= '0;
                        write_count   <= '0;
                        dropped_count <= '0;
                    end
                end
                RUN: begin
                    if (pop) begin
                        if (head_legal) begin
                            issued_count <= sat_inc(issued_count);
                            if (head_is_rd) begin
                                read_count <= sat_inc(read_count);
                            end
                            if (head_is_wr) begin
                                write_count <= sat_inc(write_count);
                            end
                        end else begin
                            dropped_count <= sat_inc(dropped_count);
                        end
                        if (head_last) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
